// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//   Instruction prefetch buffer between instruction memory and decode. Whole
//   FETCH_BYTES-wide memory words are pushed into a circular byte queue. The
//   decoder sees a 3-byte window at the head of the queue (opcode plus a
//   16-bit operand) and retires 1..3 bytes per instruction, so variable-length
//   instructions can issue back to back. A redirect from execute flushes the
//   queue and restarts fetch at the new PC.
//
// Ports
//   clk, a_rst             clock (rising edge), asynchronous active-low reset
//   i_mem_req / i_mem_pc   fetch request and byte address of the word wanted
//   i_mem_rdy / i_mem_data memory returns the word; byte 0 in [7:0]
//   pc_w / pc_new          redirect strobe and target (flushes the queue)
//   hold                   freeze: no push, no pop
//   id_consume_en/_n       decoder retires id_consume_n (1..3) bytes
//   id_win                 head, head+1, head+2 bytes; [7:0] is the opcode
//   id_avail               min(count, 3)
//   id_pc                  address of the head byte
//   q_err                  sticky flag set by an illegal consume
// -----------------------------------------------------------------------------
module prefetch_queue #(
    parameter int unsigned      FETCH_BYTES = 4,
    parameter int unsigned      DEPTH       = 16,
    parameter int unsigned      PC_W        = 16,
    parameter logic [PC_W-1:0]  RESET_PC    = PC_W'(16'hFFFC)
) (
    input  logic                     clk,
    input  logic                     a_rst,
    output logic                     i_mem_req,
    output logic [PC_W-1:0]          i_mem_pc,
    input  logic                     i_mem_rdy,
    input  logic [8*FETCH_BYTES-1:0] i_mem_data,
    input  logic                     pc_w,
    input  logic [PC_W-1:0]          pc_new,
    input  logic                     hold,
    input  logic                     id_consume_en,
    input  logic [1:0]               id_consume_n,
    output logic [23:0]              id_win,
    output logic [1:0]               id_avail,
    output logic [PC_W-1:0]          id_pc,
    output logic                     q_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  head_pc_q, head_pc_d;
    logic             q_err_q, q_err_d;

    logic [CNT_W-1:0] free_bytes;
    logic             push;
    logic             try_consume;
    logic             pop;

    // Request only when a whole word fits; redirect and hold both suppress it,
    // and it is forced low while reset is asserted.
    assign free_bytes  = CNT_W'(DEPTH) - count_q;
    assign i_mem_req   = a_rst & ~pc_w & ~hold & (free_bytes >= CNT_W'(FETCH_BYTES));
    assign i_mem_pc    = fetch_pc_q;
    assign push        = i_mem_req & i_mem_rdy;

    // A consume attempt outside hold/redirect is either a legal pop or an error.
    assign try_consume = id_consume_en & ~hold & ~pc_w;
    assign pop         = try_consume & (id_consume_n != 2'd0)
                       & (CNT_W'(id_consume_n) <= count_q);

    // NOTE: every signal assigned here gets a default first so no latch is
    // inferred on the paths that do not assign it.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        q_err_d    = q_err_q;
        if (pc_w) begin
            // Redirect discards same-cycle data and consume, without q_err.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = pc_new;
            head_pc_d  = pc_new;
        end else begin
            if (push) begin
                tail_d     = tail_q + PTR_W'(FETCH_BYTES);
                fetch_pc_d = fetch_pc_q + PC_W'(FETCH_BYTES);
            end
            if (pop) begin
                head_d    = head_q + PTR_W'(id_consume_n);
                head_pc_d = head_pc_q + PC_W'(id_consume_n);
            end
            if (try_consume && !pop) begin
                q_err_d = 1'b1;
            end
            count_d = count_q
                    + (push ? CNT_W'(FETCH_BYTES)  : CNT_W'(0))
                    - (pop  ? CNT_W'(id_consume_n) : CNT_W'(0));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            q_err_q    <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            q_err_q    <= q_err_d;
        end
    end

    // NOTE: the byte array has no reset; count gates every read, so stale
    // contents are never visible and the array can map onto plain storage.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
                mem_q[tail_q + PTR_W'(i)] <= i_mem_data[8*i +: 8];
            end
        end
    end

    // Window comes from registered state only; bytes beyond count read as 0,
    // which also keeps this cycle's pushed bytes out of view.
    always_comb begin
        id_win = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (CNT_W'(k) < count_q) begin
                id_win[8*k +: 8] = mem_q[head_q + PTR_W'(k)];
            end
        end
    end

    assign id_avail = (count_q >= CNT_W'(3)) ? 2'd3 : count_q[1:0];
    assign id_pc    = head_pc_q;
    assign q_err    = q_err_q;

endmodule
